// File: rtl/rs_param_ooo.sv
// Reservation station for one ALU: age-ordered select, N_CDB-channel
// operand wakeup, dispatch bypass and a back-pressured issue register.
module rs_param_ooo #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int IMM_W  = 32,
    parameter int OP_W   = 6,
    parameter int ADDR_W = 32,
    parameter int N_CDB  = 3,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    disp_valid,
    output logic                    disp_ready,
    input  logic [OP_W-1:0]         disp_op,
    input  logic [TAG_W-1:0]        disp_rd_tag,
    input  logic                    disp_rs1_rdy,
    input  logic [TAG_W-1:0]        disp_rs1_tag,
    input  logic [DATA_W-1:0]       disp_rs1_val,
    input  logic                    disp_rs2_rdy,
    input  logic [TAG_W-1:0]        disp_rs2_tag,
    input  logic [DATA_W-1:0]       disp_rs2_val,
    input  logic [IMM_W-1:0]        disp_imm,
    input  logic [ADDR_W-1:0]       disp_pc,
    input  logic [N_CDB-1:0]        cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [N_CDB*DATA_W-1:0] cdb_value,
    output logic                    iss_valid,
    input  logic                    iss_ready,
    output logic [OP_W-1:0]         iss_op,
    output logic [TAG_W-1:0]        iss_rd_tag,
    output logic [DATA_W-1:0]       iss_rs1_val,
    output logic [DATA_W-1:0]       iss_rs2_val,
    output logic [IMM_W-1:0]        iss_imm,
    output logic [ADDR_W-1:0]       iss_pc,
    output logic [CNT_W-1:0]        count,
    output logic                    full
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]             busy;
    logic [DEPTH-1:0]             r1_rdy;
    logic [DEPTH-1:0]             r2_rdy;
    logic [DEPTH-1:0][OP_W-1:0]   e_op;
    logic [DEPTH-1:0][TAG_W-1:0]  e_rd;
    logic [DEPTH-1:0][TAG_W-1:0]  e_r1_tag;
    logic [DEPTH-1:0][TAG_W-1:0]  e_r2_tag;
    logic [DEPTH-1:0][DATA_W-1:0] e_r1_val;
    logic [DEPTH-1:0][DATA_W-1:0] e_r2_val;
    logic [DEPTH-1:0][IMM_W-1:0]  e_imm;
    logic [DEPTH-1:0][ADDR_W-1:0] e_pc;
    // age[i][j] set: entry i is older than entry j
    logic [DEPTH-1:0][DEPTH-1:0]  age;

    logic [DEPTH-1:0]             w1_hit;
    logic [DEPTH-1:0]             w2_hit;
    logic [DEPTH-1:0][DATA_W-1:0] w1_val;
    logic [DEPTH-1:0][DATA_W-1:0] w2_val;
    logic                         d1_hit;
    logic                         d2_hit;
    logic [DATA_W-1:0]            d1_val;
    logic [DATA_W-1:0]            d2_val;

    logic [DEPTH-1:0] ent_rdy;
    logic [DEPTH-1:0] sel_oh;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic             any_rdy;
    logic             disp_fire;
    logic             iss_load;

    assign full       = (count == CNT_W'(DEPTH));
    assign disp_ready = !full;
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign ent_rdy    = busy & r1_rdy & r2_rdy;
    assign any_rdy    = |ent_rdy;
    assign iss_load   = (!iss_valid || iss_ready) && any_rdy && !flush;

    // Descending scan so the lowest channel index wins.
    always_comb begin
        d1_hit = 1'b0;
        d2_hit = 1'b0;
        d1_val = '0;
        d2_val = '0;
        w1_hit = '0;
        w2_hit = '0;
        w1_val = '0;
        w2_val = '0;
        for (int k = N_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k]) begin
                if (cdb_tag[k*TAG_W +: TAG_W] == disp_rs1_tag) begin
                    d1_hit = 1'b1;
                    d1_val = cdb_value[k*DATA_W +: DATA_W];
                end
                if (cdb_tag[k*TAG_W +: TAG_W] == disp_rs2_tag) begin
                    d2_hit = 1'b1;
                    d2_val = cdb_value[k*DATA_W +: DATA_W];
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (cdb_tag[k*TAG_W +: TAG_W] == e_r1_tag[i]) begin
                        w1_hit[i] = 1'b1;
                        w1_val[i] = cdb_value[k*DATA_W +: DATA_W];
                    end
                    if (cdb_tag[k*TAG_W +: TAG_W] == e_r2_tag[i]) begin
                        w2_hit[i] = 1'b1;
                        w2_val[i] = cdb_value[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!busy[i]) free_idx = IDX_W'(i);
    end

    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_oh[i] = ent_rdy[i];
            for (int j = 0; j < DEPTH; j++)
                if (j != i && ent_rdy[j] && !age[i][j])
                    sel_oh[i] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++)
            if (sel_oh[i]) sel_idx = IDX_W'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= '0;
            r1_rdy      <= '0;
            r2_rdy      <= '0;
            e_op        <= '0;
            e_rd        <= '0;
            e_r1_tag    <= '0;
            e_r2_tag    <= '0;
            e_r1_val    <= '0;
            e_r2_val    <= '0;
            e_imm       <= '0;
            e_pc        <= '0;
            age         <= '0;
            count       <= '0;
            iss_valid   <= 1'b0;
            iss_op      <= '0;
            iss_rd_tag  <= '0;
            iss_rs1_val <= '0;
            iss_rs2_val <= '0;
            iss_imm     <= '0;
            iss_pc      <= '0;
        end else if (flush) begin
            busy      <= '0;
            age       <= '0;
            count     <= '0;
            iss_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && !r1_rdy[i] && w1_hit[i]) begin
                    r1_rdy[i]   <= 1'b1;
                    e_r1_val[i] <= w1_val[i];
                end
                if (busy[i] && !r2_rdy[i] && w2_hit[i]) begin
                    r2_rdy[i]   <= 1'b1;
                    e_r2_val[i] <= w2_val[i];
                end
            end
            if (disp_fire) begin
                busy[free_idx]     <= 1'b1;
                e_op[free_idx]     <= disp_op;
                e_rd[free_idx]     <= disp_rd_tag;
                e_imm[free_idx]    <= disp_imm;
                e_pc[free_idx]     <= disp_pc;
                e_r1_tag[free_idx] <= disp_rs1_tag;
                e_r2_tag[free_idx] <= disp_rs2_tag;
                r1_rdy[free_idx]   <= disp_rs1_rdy || d1_hit;
                r2_rdy[free_idx]   <= disp_rs2_rdy || d2_hit;
                e_r1_val[free_idx] <= (!disp_rs1_rdy && d1_hit) ?
                                      d1_val : disp_rs1_val;
                e_r2_val[free_idx] <= (!disp_rs2_rdy && d2_hit) ?
                                      d2_val : disp_rs2_val;
                age[free_idx]      <= '0;
                for (int j = 0; j < DEPTH; j++)
                    age[j][free_idx] <= busy[j];
            end
            // Issue clears after dispatch so a leaving entry drops out of the new column.
            if (iss_load) begin
                busy[sel_idx] <= 1'b0;
                age[sel_idx]  <= '0;
                for (int j = 0; j < DEPTH; j++)
                    age[j][sel_idx] <= 1'b0;
                iss_valid   <= 1'b1;
                iss_op      <= e_op[sel_idx];
                iss_rd_tag  <= e_rd[sel_idx];
                iss_rs1_val <= e_r1_val[sel_idx];
                iss_rs2_val <= e_r2_val[sel_idx];
                iss_imm     <= e_imm[sel_idx];
                iss_pc      <= e_pc[sel_idx];
            end else if (iss_ready) begin
                iss_valid <= 1'b0;
            end
            count <= count + CNT_W'(disp_fire) - CNT_W'(iss_load);
        end
    end

endmodule

// File: tb/tb_rs_param_ooo.sv
// Bench for rs_param_ooo: directed scenarios plus random traffic against
// an in-order queue model of the station.
module tb_rs_param_ooo;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int IMM_W  = 32;
    localparam int OP_W   = 6;
    localparam int ADDR_W = 32;
    localparam int N_CDB  = 3;
    localparam int CNT_W  = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    disp_valid;
    logic                    disp_ready;
    logic [OP_W-1:0]         disp_op;
    logic [TAG_W-1:0]        disp_rd_tag;
    logic                    disp_rs1_rdy;
    logic [TAG_W-1:0]        disp_rs1_tag;
    logic [DATA_W-1:0]       disp_rs1_val;
    logic                    disp_rs2_rdy;
    logic [TAG_W-1:0]        disp_rs2_tag;
    logic [DATA_W-1:0]       disp_rs2_val;
    logic [IMM_W-1:0]        disp_imm;
    logic [ADDR_W-1:0]       disp_pc;
    logic [N_CDB-1:0]        cdb_valid;
    logic [N_CDB*TAG_W-1:0]  cdb_tag;
    logic [N_CDB*DATA_W-1:0] cdb_value;
    logic                    iss_valid;
    logic                    iss_ready;
    logic [OP_W-1:0]         iss_op;
    logic [TAG_W-1:0]        iss_rd_tag;
    logic [DATA_W-1:0]       iss_rs1_val;
    logic [DATA_W-1:0]       iss_rs2_val;
    logic [IMM_W-1:0]        iss_imm;
    logic [ADDR_W-1:0]       iss_pc;
    logic [CNT_W-1:0]        count;
    logic                    full;

    always #5 clk = ~clk;

    rs_param_ooo #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W),
        .IMM_W(IMM_W), .OP_W(OP_W), .ADDR_W(ADDR_W),
        .N_CDB(N_CDB), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_op(disp_op), .disp_rd_tag(disp_rd_tag),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag),
        .disp_rs1_val(disp_rs1_val), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs2_tag(disp_rs2_tag), .disp_rs2_val(disp_rs2_val),
        .disp_imm(disp_imm), .disp_pc(disp_pc),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_op(iss_op), .iss_rd_tag(iss_rd_tag),
        .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val),
        .iss_imm(iss_imm), .iss_pc(iss_pc),
        .count(count), .full(full)
    );

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  rd;
        logic              r1r;
        logic [TAG_W-1:0]  r1t;
        logic [DATA_W-1:0] r1v;
        logic              r2r;
        logic [TAG_W-1:0]  r2t;
        logic [DATA_W-1:0] r2v;
        logic [IMM_W-1:0]  imm;
        logic [ADDR_W-1:0] pc;
    } ent_t;

    // Model: queue in dispatch order, oldest at the front.
    ent_t q[$];
    ent_t m_iss;
    logic m_iv;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cdb_lookup(input logic [TAG_W-1:0] t,
                                        output logic [DATA_W-1:0] v);
        logic found;
        found = 1'b0;
        v = '0;
        for (int k = 0; k < N_CDB; k++)
            if (!found && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == t) begin
                found = 1'b1;
                v = cdb_value[k*DATA_W +: DATA_W];
            end
        return found;
    endfunction

    task automatic model_reset();
        q.delete();
        m_iv  = 1'b0;
        m_iss = '{default: '0};
    endtask

    task automatic model_edge();
        int sel;
        logic fire;
        logic load;
        logic [DATA_W-1:0] v;
        ent_t e;
        if (!rst) begin
            model_reset();
            return;
        end
        if (flush) begin
            q.delete();
            m_iv = 1'b0;
            return;
        end
        fire = disp_valid && (q.size() < DEPTH);
        sel = -1;
        for (int i = 0; i < q.size(); i++)
            if (sel < 0 && q[i].r1r && q[i].r2r) sel = i;
        load = (!m_iv || iss_ready) && (sel >= 0);
        for (int i = 0; i < q.size(); i++) begin
            if (!q[i].r1r && cdb_lookup(q[i].r1t, v)) begin
                q[i].r1r = 1'b1;
                q[i].r1v = v;
            end
            if (!q[i].r2r && cdb_lookup(q[i].r2t, v)) begin
                q[i].r2r = 1'b1;
                q[i].r2v = v;
            end
        end
        if (load) begin
            m_iss = q[sel];
            m_iv  = 1'b1;
            q.delete(sel);
        end else if (iss_ready) begin
            m_iv = 1'b0;
        end
        if (fire) begin
            e.op  = disp_op;
            e.rd  = disp_rd_tag;
            e.imm = disp_imm;
            e.pc  = disp_pc;
            e.r1t = disp_rs1_tag;
            e.r2t = disp_rs2_tag;
            e.r1r = disp_rs1_rdy;
            e.r1v = disp_rs1_val;
            e.r2r = disp_rs2_rdy;
            e.r2v = disp_rs2_val;
            if (!e.r1r && cdb_lookup(e.r1t, v)) begin
                e.r1r = 1'b1;
                e.r1v = v;
            end
            if (!e.r2r && cdb_lookup(e.r2t, v)) begin
                e.r2r = 1'b1;
                e.r2v = v;
            end
            q.push_back(e);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".iss_valid"}, iss_valid, m_iv);
        chk({ph, ".count"}, count, q.size());
        chk({ph, ".full"}, full, q.size() == DEPTH);
        chk({ph, ".disp_ready"}, disp_ready, q.size() != DEPTH);
        if (m_iv) begin
            chk({ph, ".op"}, iss_op, m_iss.op);
            chk({ph, ".rd"}, iss_rd_tag, m_iss.rd);
            chk({ph, ".rs1"}, iss_rs1_val, m_iss.r1v);
            chk({ph, ".rs2"}, iss_rs2_val, m_iss.r2v);
            chk({ph, ".imm"}, iss_imm, m_iss.imm);
            chk({ph, ".pc"}, iss_pc, m_iss.pc);
        end
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_edge();
        #1 check_all(ph);
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = '0;
        flush      = 1'b0;
    endtask

    task automatic set_disp(input logic [OP_W-1:0] op,
                            input logic [TAG_W-1:0] rd,
                            input logic r1r, input logic [TAG_W-1:0] r1t,
                            input logic [DATA_W-1:0] r1v,
                            input logic r2r, input logic [TAG_W-1:0] r2t,
                            input logic [DATA_W-1:0] r2v);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_rd_tag  = rd;
        disp_rs1_rdy = r1r;
        disp_rs1_tag = r1t;
        disp_rs1_val = r1v;
        disp_rs2_rdy = r2r;
        disp_rs2_tag = r2t;
        disp_rs2_val = r2v;
        disp_imm     = $urandom;
        disp_pc      = $urandom;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        iss_ready = 1'b0;
        cdb_tag = '0;
        cdb_value = '0;
        set_disp('0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        idle();
        model_reset();
        #1;
        chk("rst.iss_valid", iss_valid, 1'b0);
        chk("rst.count", count, '0);
        chk("rst.full", full, 1'b0);
        chk("rst.disp_ready", disp_ready, 1'b1);
        chk("rst.iss_rd", iss_rd_tag, '0);
        chk("rst.iss_rs1", iss_rs1_val, '0);
        chk("rst.iss_pc", iss_pc, '0);
        @(negedge clk);
        rst = 1'b1;

        // single ready instruction
        iss_ready = 1'b1;
        set_disp(6'h01, 4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
        step("t1.disp");
        idle();
        step("t1.iss");
        chk("t1.valid", iss_valid, 1'b1);
        chk("t1.rd", iss_rd_tag, 4'd3);
        chk("t1.rs1", iss_rs1_val, 32'd5);
        chk("t1.rs2", iss_rs2_val, 32'd7);
        chk("t1.count", count, '0);
        step("t1.drain");

        // age order with a shared producer tag
        set_disp(6'h02, 4'd10, 1'b0, 4'd2, 32'h0, 1'b1, 4'd0, 32'h22);
        step("t2.dispA");
        set_disp(6'h03, 4'd11, 1'b1, 4'd0, 32'h1, 1'b1, 4'd0, 32'h2);
        step("t2.dispB");
        set_disp(6'h04, 4'd12, 1'b1, 4'd0, 32'h33, 1'b0, 4'd2, 32'h0);
        step("t2.dispC");
        chk("t2.first_rd", iss_rd_tag, 4'd11);
        idle();
        cdb_valid = 3'b010;
        cdb_tag[TAG_W +: TAG_W] = 4'd2;
        cdb_value[DATA_W +: DATA_W] = 32'hAA;
        step("t2.wake");
        idle();
        step("t2.issA");
        chk("t2.A_rd", iss_rd_tag, 4'd10);
        chk("t2.A_rs1", iss_rs1_val, 32'hAA);
        step("t2.issC");
        chk("t2.C_rd", iss_rd_tag, 4'd12);
        chk("t2.C_rs2", iss_rs2_val, 32'hAA);

        // dispatch bypass on both operands
        set_disp(6'h05, 4'd13, 1'b0, 4'd4, 32'h0, 1'b0, 4'd4, 32'h0);
        cdb_valid = 3'b001;
        cdb_tag[0 +: TAG_W] = 4'd4;
        cdb_value[0 +: DATA_W] = 32'h55;
        step("t3.disp");
        idle();
        step("t3.iss");
        chk("t3.valid", iss_valid, 1'b1);
        chk("t3.rs1", iss_rs1_val, 32'h55);
        chk("t3.rs2", iss_rs2_val, 32'h55);

        // fill to DEPTH under back-pressure
        iss_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_disp(6'h06, 4'(i), 1'b1, 4'd0, 32'(i), 1'b1, 4'd0, 32'(i));
            step("t4.fill");
        end
        chk("t4.full", full, 1'b1);
        chk("t4.count", count, 5'd16);
        chk("t4.disp_ready", disp_ready, 1'b0);
        idle();
        iss_ready = 1'b1;
        step("t4.pop");
        chk("t4.count15", count, 5'd15);
        chk("t4.ready_again", disp_ready, 1'b1);

        // hold under back-pressure, then flush with a dropped dispatch
        iss_ready = 1'b0;
        for (int i = 0; i < 5; i++) step("t5.hold");
        flush = 1'b1;
        set_disp(6'h07, 4'd14, 1'b1, 4'd0, 32'h9, 1'b1, 4'd0, 32'h9);
        step("t5.flush");
        chk("t5.iss_valid", iss_valid, 1'b0);
        chk("t5.count", count, '0);
        idle();
        step("t5.after");
        chk("t5.dropped", count, '0);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            disp_valid   = $urandom_range(0, 99) < 60;
            disp_op      = 6'($urandom);
            disp_rd_tag  = 4'($urandom);
            disp_rs1_rdy = 1'($urandom_range(0, 1));
            disp_rs1_tag = 4'($urandom_range(0, 7));
            disp_rs1_val = $urandom;
            disp_rs2_rdy = 1'($urandom_range(0, 1));
            disp_rs2_tag = 4'($urandom_range(0, 7));
            disp_rs2_val = $urandom;
            disp_imm     = $urandom;
            disp_pc      = $urandom;
            cdb_valid    = 3'($urandom);
            for (int k = 0; k < N_CDB; k++) begin
                cdb_tag[k*TAG_W +: TAG_W]    = 4'($urandom_range(0, 7));
                cdb_value[k*DATA_W +: DATA_W] = $urandom;
            end
            iss_ready = $urandom_range(0, 99) < 70;
            flush     = $urandom_range(0, 99) < 2;
            step("rand");
        end

        // asynchronous reset between edges
        idle();
        flush = 1'b1;
        step("t6.clear");
        idle();
        iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_disp(6'h08, 4'(i), 1'b1, 4'd0, 32'h1, 1'b1, 4'd0, 32'h2);
            step("t6.load");
        end
        idle();
        chk("t6.pre_valid", iss_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t6.async_valid", iss_valid, 1'b0);
        chk("t6.async_count", count, '0);
        chk("t6.async_full", full, 1'b0);
        model_reset();
        step("t6.held");
        @(negedge clk);
        rst = 1'b1;
        step("t6.release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_param_ooo.md
Name: rs_param_ooo

Overview:
- Parametrised reservation station for the out-of-order core. Sits between the decoder/rename stage and one execution unit (ALU).
- Holds DEPTH renamed instructions and snoops N_CDB broadcast channels for operand wakeup.
- Issues the oldest ready entry through a valid/ready handshake.
- Supersedes the fixed 16-entry station:
  - per-operand ready bits replace the sentinel tag;
  - wakeup is multi-channel;
  - both operands are checked independently;
  - selection is age-ordered;
  - issue has back-pressure.

Parameters:
- DEPTH, 16: number of entries, at least 2.
- TAG_W, 4: ROB tag width.
- DATA_W, 32: operand width.
- IMM_W, 32: immediate width.
- OP_W, 6: opcode width.
- ADDR_W, 32: PC width.
- N_CDB, 3: number of broadcast channels (ALU, LSB, ROB).
- CNT_W, $clog2(DEPTH+1): occupancy counter width.

Ports:
- clk, in, 1: clock; all state changes on posedge.
- rst, in, 1: asynchronous, active-low reset.
- flush, in, 1: mispredict flush, synchronous.
- disp_valid, in, 1: decoder presents an instruction.
- disp_ready, out, 1: station can accept; equals !full.
- disp_op, in, OP_W: opcode.
- disp_rd_tag, in, TAG_W: destination ROB tag.
- disp_rs1_rdy, in, 1: rs1 value is valid (no pending producer).
- disp_rs1_tag, in, TAG_W: rs1 producer tag.
- disp_rs1_val, in, DATA_W: rs1 value.
- disp_rs2_rdy, in, 1: rs2 value is valid.
- disp_rs2_tag, in, TAG_W: rs2 producer tag.
- disp_rs2_val, in, DATA_W: rs2 value.
- disp_imm, in, IMM_W: immediate.
- disp_pc, in, ADDR_W: instruction PC.
- cdb_valid, in, N_CDB: per-channel broadcast strobe.
- cdb_tag, in, N_CDB*TAG_W: channel k occupies bits [k*TAG_W +: TAG_W].
- cdb_value, in, N_CDB*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
- iss_valid, out, 1: issue register holds an instruction.
- iss_ready, in, 1: execution unit accepts.
- iss_op, out, OP_W: issued opcode.
- iss_rd_tag, out, TAG_W: issued destination tag.
- iss_rs1_val, out, DATA_W: issued rs1 value.
- iss_rs2_val, out, DATA_W: issued rs2 value.
- iss_imm, out, IMM_W: issued immediate.
- iss_pc, out, ADDR_W: issued PC.
- count, out, CNT_W: occupied entries.
- full, out, 1: count == DEPTH.

Behaviour:
- Reset (rst low, asynchronous): all entry busy bits 0, age matrix 0, iss_valid 0, count 0, full 0. All iss_* data outputs 0.
- Entry state: busy, op, rd_tag, rs1/rs2 {rdy, tag, val}, imm, pc. Age is an age matrix: age[i][j]=1 means entry i is older than entry j.
- Dispatch fires when disp_valid && disp_ready && !flush.
  - Target is the lowest-index free entry.
  - Each operand is stored as presented. Exception: if the operand is not ready and a cdb_valid[k] channel carries a matching tag in the same cycle, the operand is captured ready with that cdb value (dispatch bypass).
  - If several channels match, the lowest k wins.
  - The new entry is marked younger than every busy entry.
- Wakeup: every cycle, for every busy entry, each operand (rs1 and rs2 independently) with rdy=0 whose tag matches an active channel takes rdy=1 and that channel's value. Lowest k wins on multiple matches.
- Ready and select:
  - An entry is ready when busy && rs1.rdy && rs2.rdy, using registered state. An operand woken this cycle makes its entry eligible at the next edge.
  - Select = the ready entry older than all other ready entries (oldest first).
- Issue register loads when (!iss_valid || iss_ready) && any ready && !flush.
  - Loads all fields of the selected entry and sets iss_valid=1.
  - Clears the entry's busy bit and its age row and column.
  - Latency: from last operand wakeup edge to iss_valid is 1 cycle when the issue register is free.
- Hold: while iss_valid && !iss_ready, iss_* fields and iss_valid are stable.
- Drain: when iss_ready && nothing is ready, iss_valid goes to 0 at the next edge.
- Simultaneous dispatch and issue:
  - Both take effect; count is unchanged.
  - The freed slot is not reusable in the same cycle, because disp_ready is computed from registered count.
  - Dispatch into a just-freed slot is possible the next cycle.
- count changes by +1 on dispatch, -1 on issue load, 0 on both; saturation is impossible by construction. full = (count == DEPTH).
- flush (when rst high): at the next edge all busy bits 0, age matrix 0, iss_valid 0, count 0. flush overrides dispatch, wakeup and issue in that cycle; disp_ready still reflects pre-flush state.
- Reset asserted mid-operation clears state immediately, independent of clk.
- Tag 0 is a valid tag; there is no sentinel value.

Test Plan:
- Reset then dispatch 1 entry with both operands ready (op=6'h01, rd=3, rs1=5, rs2=7), iss_ready=1. Required: iss_valid the next cycle with rd_tag=3, rs1=5, rs2=7; count returns to 0.
- Dispatch entries A (rs1 waits on tag 2), then B (ready), then C (rs2 waits on tag 2). Required: B issues first. Then drive cdb ch1 tag=2 value=0xAA: A and C both capture 0xAA; A issues before C (age order).
- Dispatch with rs1 tag 4 and rs2 tag 4, both not ready, while ch0 broadcasts tag 4 value 0x55 in the same cycle. Required: entry issues the next cycle with rs1=rs2=0x55 (bypass, both operands).
- Fill DEPTH=16 with iss_ready=0. Required: full=1, disp_ready=0, count=16; a 17th disp_valid is ignored. iss_ready=1 for one cycle: count=15, disp_ready=1 the next cycle.
- Hold iss_ready=0 with iss_valid=1 for 5 cycles. Required: iss_* stable. Then assert flush: iss_valid=0 and count=0 the next cycle, and a dispatch in the flush cycle is dropped.
- Pull rst low between edges mid-stream. Required: iss_valid and count drop to 0 immediately, without a clock edge.
